// File: rtl/ctrl_pkg.sv
// Shared control-unit definitions: switch bus width, debounce defaults and the
// per-bit debounce state encoding.
package ctrl_pkg;

  localparam int DSW_WIDTH       = 4;
  localparam int DSW_SYNC_STAGES = 2;
  localparam int DEBOUNCE_CYCLES = 16;

  // Bit 1 of the encoding is the currently accepted (stable) level.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    PEND_LO   = 2'b10,
    STABLE_HI = 2'b11
  } deb_state_e;

endpackage : ctrl_pkg

// File: rtl/bit_debounce.sv
// One switch bit: synchronizer chain, debounce FSM with persistence counter,
// and registered rise/fall strobes aligned with the stable level update.
module bit_debounce
  import ctrl_pkg::*;
#(
  parameter int SYNC_STAGES   = DSW_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int                CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   stable_q;
  logic                   rise_q;
  logic                   fall_q;

  // NOTE: the synchronizer is reset too, so a level held high through reset is
  // re-sampled from scratch and accepted with the normal latency and a rise pulse.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: all state here uses <= so every branch reads the pre-edge values of
  // state_q and cnt_q, whatever order the assignments appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (s) begin
            state_q <= PEND_HI;
            cnt_q   <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
          end
        end
        PEND_HI: begin
          if (!s) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q  <= STABLE_HI;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            rise_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state_q <= PEND_LO;
            cnt_q   <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
          end
        end
        PEND_LO: begin
          if (s) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q  <= STABLE_LO;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            fall_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= STABLE_LO;
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end
      endcase
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule : bit_debounce

// File: rtl/dsw_debouncer.sv
// DIP-switch conditioning: per-bit synchronize + debounce, with a bus-level
// change strobe for the control unit.
module dsw_debouncer
  import ctrl_pkg::*;
#(
  parameter int WIDTH         = DSW_WIDTH,
  parameter int SYNC_STAGES   = DSW_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             sw_changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bit_debounce #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit_debounce (
      .clk   (clk),
      .rst   (rst),
      .sw_raw(sw_raw[i]),
      .stable(sw_stable[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // Strobes are already registered, so the bus strobe is one cycle wide even
  // when several bits are accepted on the same edge.
  assign sw_changed = |(rise | fall);

endmodule : dsw_debouncer

// File: tb/tb_dsw_debouncer.sv
// Self-checking bench for dsw_debouncer: directed scenarios with literal
// expectations plus randomized stimulus against a sliding-window model.
module tb_dsw_debouncer;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int N  = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_stable;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         sw_changed;

  int errors = 0;
  int checks = 0;

  dsw_debouncer #(
    .WIDTH        (W),
    .SYNC_STAGES  (SS),
    .STABLE_CYCLES(N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .rise      (rise),
    .fall      (fall),
    .sw_changed(sw_changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a raw level reaches the debouncer SS edges after it is
  // sampled; a bit flips when the last N delayed samples all disagree with it.
  logic [W-1:0] pipe [SS];
  logic [W-1:0] win [$];
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] m_rise   = '0;
  logic [W-1:0] m_fall   = '0;
  logic [W-1:0] m_s;
  logic         all_diff;

  initial for (int k = 0; k < SS; k++) pipe[k] = '0;

  always @(posedge clk) begin
    m_rise = '0;
    m_fall = '0;
    if (rst) begin
      for (int k = 0; k < SS; k++) pipe[k] = '0;
      win.delete();
      m_stable = '0;
    end else begin
      m_s = pipe[SS-1];
      for (int k = SS - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = sw_raw;
      win.push_back(m_s);
      if (win.size() > N) void'(win.pop_front());
      if (win.size() == N) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          foreach (win[j]) if (win[j][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[b] = ~m_stable[b];
            if (m_stable[b]) m_rise[b] = 1'b1;
            else             m_fall[b] = 1'b1;
          end
        end
      end
    end
    #1;
    check("model_sw_stable", sw_stable, m_stable);
    check("model_rise", rise, m_rise);
    check("model_fall", fall, m_fall);
    check("model_sw_changed", sw_changed, |(m_rise | m_fall));
    check("rise_fall_exclusive", rise & fall, '0);
  end

  // Inputs change 2 time units after the edge, after the model has compared.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [W-1:0] raw);
    rst    = 1'b1;
    sw_raw = raw;
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    rst    = 1'b1;
    sw_raw = 4'b1010;

    // 1: level held through reset is accepted at edge 6 after release
    tick();
    tick();
    check("t1_rst_stable", sw_stable, 4'b0000);
    check("t1_rst_rise", rise, 4'b0000);
    check("t1_rst_fall", fall, 4'b0000);
    check("t1_rst_changed", sw_changed, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t1_pre_stable", sw_stable, 4'b0000);
    end
    tick();
    check("t1_e6_stable", sw_stable, 4'b1010);
    check("t1_e6_rise", rise, 4'b1010);
    check("t1_e6_changed", sw_changed, 1'b1);
    tick();
    check("t1_e7_rise", rise, 4'b0000);
    check("t1_e7_changed", sw_changed, 1'b0);
    check("t1_e7_stable", sw_stable, 4'b1010);

    // 2: bouncing bit0 accepted only 6 edges after the final settle
    do_reset(4'b0000);
    for (int i = 0; i < 4; i++) begin
      sw_raw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      check("t2_bounce_rise", rise, 4'b0000);
    end
    sw_raw = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t2_pre_stable", sw_stable, 4'b0000);
      check("t2_pre_rise", rise, 4'b0000);
    end
    tick();
    check("t2_e6_stable", sw_stable, 4'b0001);
    check("t2_e6_rise", rise, 4'b0001);

    // 3: a 3-edge pulse on bit2 is one short of acceptance
    do_reset(4'b0000);
    sw_raw = 4'b0100;
    repeat (3) tick();
    sw_raw = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_stable", sw_stable, 4'b0000);
      check("t3_rise", rise, 4'b0000);
      check("t3_fall", fall, 4'b0000);
    end

    // 4: two bits falling together give one sw_changed pulse
    do_reset(4'b1111);
    check("t4_init_stable", sw_stable, 4'b1111);
    sw_raw = 4'b0101;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t4_pre_changed", sw_changed, 1'b0);
    end
    tick();
    check("t4_e6_fall", fall, 4'b1010);
    check("t4_e6_rise", rise, 4'b0000);
    check("t4_e6_changed", sw_changed, 1'b1);
    check("t4_e6_stable", sw_stable, 4'b0101);
    tick();
    check("t4_e7_changed", sw_changed, 1'b0);

    // 5: reset mid-count discards the pending count
    do_reset(4'b0000);
    sw_raw = 4'b1000;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("t5_rst_stable", sw_stable, 4'b0000);
    check("t5_rst_rise", rise, 4'b0000);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t5_pre_stable", sw_stable, 4'b0000);
    end
    tick();
    check("t5_e6_stable", sw_stable, 4'b1000);
    check("t5_e6_rise", rise, 4'b1000);

    // 6: random bouncing with rare resets, checked by the model every cycle
    do_reset(4'b0000);
    for (int i = 0; i < 10000; i++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) sw_raw[b] = ~sw_raw[b];
      rst = ($urandom_range(0, 1999) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (12) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dsw_debouncer
